// File: rtl/sound_pcm.sv
// 1-bit sound level to signed 16-bit PCM: synchroniser, idle detect, IIR low-pass, decimator.
// Define SOUND_PCM_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module sound_pcm #(
    parameter int CLK_HZ       = 7_159_000,
    parameter int SAMPLE_HZ    = 48_000,
    parameter int AMP          = 8192,
    parameter int FILTER_SHIFT = 8,
    parameter int IDLE_TICKS   = 256
) (
    input  logic               clk7_159,
    input  logic               _reset,
    input  logic               sound_in,
    input  logic               sample_ready,
    output logic               sample_valid,
    output logic signed [15:0] sample,
    output logic               active
`ifdef SOUND_PCM_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int ACC_W = $clog2(CLK_HZ + SAMPLE_HZ) + 1;
    localparam int CNT_W = $clog2(IDLE_TICKS + 1);

    localparam logic [ACC_W-1:0]  ACC_STEP  = ACC_W'(SAMPLE_HZ);
    localparam logic [ACC_W-1:0]  ACC_LIMIT = ACC_W'(CLK_HZ);
    localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'(IDLE_TICKS);
    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_TICKS - 1);
    localparam logic signed [23:0] TGT_HI   = 24'(AMP * 256);
    localparam logic signed [23:0] TGT_LO   = -TGT_HI;

    logic                     s_meta, s, s_d;
    logic [ACC_W-1:0]         acc;
    logic [CNT_W-1:0]         idle_cnt;
    logic signed [23:0]       y;

    logic                     edge_det;
    logic                     tick;
    logic [ACC_W-1:0]         acc_nxt;
    logic signed [23:0]       target;
    logic signed [24:0]       diff;
    logic signed [23:0]       y_next;

    // NOTE: every variable assigned in always_comb gets a default first so no latch can form.
    always_comb begin
        edge_det = (s != s_d);
        acc_nxt  = acc + ACC_STEP;
        tick     = (acc_nxt >= ACC_LIMIT);
        target   = '0;
        if (active)
            target = s ? TGT_HI : TGT_LO;
        // 25-bit difference cannot overflow; the shifted value always fits back into 24 bits.
        diff   = {target[23], target} - {y[23], y};
        y_next = y + 24'(diff >>> FILTER_SHIFT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= sound_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset)
            acc <= '0;
        else if (tick)
            acc <= acc_nxt - ACC_LIMIT;
        else
            acc <= acc_nxt;
    end

    // An edge beats a coincident tick; active drops on the tick that brings the count to IDLE_TICKS.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            idle_cnt <= '0;
            active   <= 1'b0;
        end else if (edge_det) begin
            idle_cnt <= '0;
            active   <= 1'b1;
        end else if (tick && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_LAST)
                active <= 1'b0;
        end
    end

    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset)
            y <= '0;
        else
            y <= y_next;
    end

    // Latest sample wins: a tick always reloads, even over an unaccepted sample.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (tick) begin
            sample       <= y[23:8];
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

`ifdef SOUND_PCM_OVERRUN_CNT_EN
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset)
            overrun_cnt <= '0;
        else if (tick && sample_valid && !sample_ready && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`else
    // Without the counter an overrun simply replaces the held sample.
`endif

endmodule
